if_stage_fetchq: RTL and testbench

//  Parametrised pre-IF/IF fetch unit. It keeps up to MAX_OUTST instruction requests in flight on
//  the SRAM-like inst port and buffers returned instructions in an IBUF_DEPTH-entry queue ahead of ID.
//  It drops stale responses after a redirect (exception, ertn, branch) by counting them.

---
 rtl/if_stage_fetchq.sv | 194 +++++++++++++++++++
 tb/tb_if_stage_fetchq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_fetchq.sv
// rtl/if_stage_fetchq.sv - fetch unit with outstanding-request tracking and instruction queue ahead of ID
// Optional IF_BYPASS_EN: a response arriving at an empty queue is presented to ID in the same cycle.
module if_stage_fetchq #(
    parameter logic [31:0] PC_RESET   = 32'h1C000000,
    parameter int          IBUF_DEPTH = 4,
    parameter int          MAX_OUTST  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic [33:0] br_bus,
    input  logic        wb_ex,
    input  logic        wb_ertn,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    output logic        fs_to_ds_valid,
    output logic [64:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [3:0]  inst_sram_wstrb,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok
);

    localparam int OW  = $clog2(MAX_OUTST + 1);
    localparam int QW  = $clog2(IBUF_DEPTH + 1);
    localparam int QPW = $clog2(IBUF_DEPTH);
    localparam int TPW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic [31:0]    fetch_pc;
    logic [31:0]    pend_addr;
    logic           pend;
    logic           stale;
    logic           halt;
    logic [OW-1:0]  outst;
    logic [OW-1:0]  outst_n;
    logic [OW-1:0]  discard;
    logic [OW-1:0]  discard_n;

    logic [64:0]    q_mem [IBUF_DEPTH];
    logic [QPW-1:0] q_head;
    logic [QPW-1:0] q_tail;
    logic [QW-1:0]  q_count;
    logic [31:0]    tag_mem [MAX_OUTST];
    logic [TPW-1:0] tag_wp;
    logic [TPW-1:0] tag_rp;

    logic           br_cancel;
    logic           br_taken;
    logic           redirect;
    logic           flush;
    logic [31:0]    target;
    logic           can_issue;
    logic           hs;
    logic           q_empty;
    logic           q_full;
    logic           bypass;
    logic           push_resp;
    logic           adef_push;
    logic           q_push;
    logic           q_pop;
    logic [64:0]    resp_entry;
    logic [64:0]    q_wdata;

    function automatic logic [TPW-1:0] tag_next(input logic [TPW-1:0] p);
        return (int'(p) == MAX_OUTST - 1) ? '0 : p + TPW'(1);
    endfunction

    assign br_cancel = br_bus[33];
    assign br_taken  = br_bus[32];
    assign redirect  = wb_ex | wb_ertn | br_taken;
    assign flush     = redirect | br_cancel;

    always_comb begin
        target = br_bus[31:0];
        if (wb_ex)
            target = csr_eentry;
        else if (wb_ertn)
            target = csr_era;
    end

    // A request once raised stays up with its address until accepted, even across a redirect.
    assign can_issue = ~pend & ~stale & ~halt & (fetch_pc[1:0] == 2'b00)
                     & ((int'(outst) + int'(q_count)) < IBUF_DEPTH)
                     & (int'(outst) < MAX_OUTST);
    assign inst_sram_req   = ~reset & (pend | can_issue);
    assign inst_sram_addr  = pend ? pend_addr : fetch_pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wdata = 32'h0;
    assign hs              = inst_sram_req & inst_sram_addr_ok;

    assign q_empty    = (q_count == '0);
    assign q_full     = (q_count == QW'(IBUF_DEPTH));
    assign resp_entry = {1'b0, inst_sram_rdata, tag_mem[tag_rp]};

`ifdef IF_BYPASS_EN
    assign bypass = ~reset & inst_sram_data_ok & q_empty & (discard == '0) & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign fs_to_ds_valid = ~reset & (~q_empty | bypass);
    assign fs_to_ds_bus   = bypass ? resp_entry : q_mem[q_head];
    assign q_pop          = ~reset & ~q_empty & ds_allowin;

    assign push_resp = inst_sram_data_ok & (discard == '0) & ~redirect & ~(bypass & ds_allowin);
    assign adef_push = (fetch_pc[1:0] != 2'b00) & ~halt & ~pend & (outst == '0)
                     & (discard == '0) & ~q_full & ~flush;
    assign q_push    = push_resp | adef_push;
    assign q_wdata   = adef_push ? {1'b1, 32'h0, fetch_pc} : resp_entry;

    always_comb begin
        outst_n = outst;
        if (hs & ~inst_sram_data_ok)
            outst_n = outst + OW'(1);
        else if (~hs & inst_sram_data_ok)
            outst_n = outst - OW'(1);
    end

    // After a redirect every request still in flight is stale, so discard tracks outst exactly.
    always_comb begin
        discard_n = discard;
        if (redirect)
            discard_n = outst_n;
        else begin
            case ({hs & stale, inst_sram_data_ok & (discard != '0)})
                2'b10:   discard_n = discard + OW'(1);
                2'b01:   discard_n = discard - OW'(1);
                default: discard_n = discard;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= PC_RESET;
            pend      <= 1'b0;
            pend_addr <= 32'h0;
            stale     <= 1'b0;
            halt      <= 1'b0;
            outst     <= '0;
            discard   <= '0;
            q_head    <= '0;
            q_tail    <= '0;
            q_count   <= '0;
            tag_wp    <= '0;
            tag_rp    <= '0;
        end else begin
            outst     <= outst_n;
            discard   <= discard_n;
            pend      <= inst_sram_req & ~inst_sram_addr_ok;
            if (inst_sram_req & ~inst_sram_addr_ok)
                pend_addr <= inst_sram_addr;
            stale     <= redirect ? (inst_sram_req & ~inst_sram_addr_ok) : (stale & ~hs);
            if (redirect)
                halt <= 1'b0;
            else if (adef_push)
                halt <= 1'b1;
            if (redirect)
                fetch_pc <= target;
            else if (hs & ~stale)
                fetch_pc <= fetch_pc + 32'd4;
            if (hs)
                tag_wp <= tag_next(tag_wp);
            if (inst_sram_data_ok)
                tag_rp <= tag_next(tag_rp);
            if (flush) begin
                q_head  <= '0;
                q_tail  <= q_push ? QPW'(1) : '0;
                q_count <= q_push ? QW'(1) : '0;
            end else begin
                if (q_push)
                    q_tail <= q_tail + QPW'(1);
                if (q_pop)
                    q_head <= q_head + QPW'(1);
                q_count <= q_count + QW'(q_push) - QW'(q_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (q_push)
            q_mem[flush ? '0 : q_tail] <= q_wdata;
        if (hs)
            tag_mem[tag_wp] <= inst_sram_addr;
    end

endmodule

// File: tb/tb_if_stage_fetchq.sv
// tb/tb_if_stage_fetchq.sv - scoreboard bench for if_stage_fetchq
module tb_if_stage_fetchq;

    localparam int MAXO = 2;
`ifdef IF_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [31:0] a;
        int          rdy;
    } pend_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_allowin;
    logic [33:0] br_bus;
    logic        wb_ex;
    logic        wb_ertn;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic        fs_to_ds_valid;
    logic [64:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [3:0]  inst_sram_wstrb;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;

    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    int          hs_cnt     = 0;
    int          first_dok  = -1;
    int          first_valid = -1;
    int          max_pend   = 0;
    int          h0;
    bit          resp_en    = 1'b1;
    logic [64:0] exp_id[$];
    logic [31:0] exp_addr[$];
    int          pop_cyc[$];
    pend_t       pend_q[$];

    if_stage_fetchq dut (
        .clk              (clk),
        .reset            (reset),
        .ds_allowin       (ds_allowin),
        .br_bus           (br_bus),
        .wb_ex            (wb_ex),
        .wb_ertn          (wb_ertn),
        .csr_eentry       (csr_eentry),
        .csr_era          (csr_era),
        .fs_to_ds_valid   (fs_to_ds_valid),
        .fs_to_ds_bus     (fs_to_ds_bus),
        .inst_sram_req    (inst_sram_req),
        .inst_sram_wr     (inst_sram_wr),
        .inst_sram_wstrb  (inst_sram_wstrb),
        .inst_sram_size   (inst_sram_size),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_wdata  (inst_sram_wdata),
        .inst_sram_rdata  (inst_sram_rdata),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEADBEEF;
    endfunction

    function automatic logic [64:0] id_of(input logic [31:0] a);
        return {1'b0, inst_of(a), a};
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_id.delete();
        exp_addr.delete();
        pop_cyc.delete();
        first_dok   = -1;
        first_valid = -1;
        @(negedge clk);
        chk("rst_req", inst_sram_req, 0);
        chk("rst_valid", fs_to_ds_valid, 0);
        step(2);
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        ds_allowin = 1'b1;
        while (exp_id.size() != 0 && n < 300) begin
            step(1);
            n++;
        end
        ds_allowin = 1'b0;
        if (exp_id.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: %0d entries left, expected 0", name, exp_id.size());
        end
    endtask

    // Memory responder: in-order data_ok, LAT-independent fixed delay of 1 cycle after acceptance.
    initial begin
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend_q.delete();
            end else begin
                if (inst_sram_data_ok && pend_q.size() > 0)
                    void'(pend_q.pop_front());
                if (inst_sram_req && inst_sram_addr_ok)
                    pend_q.push_back('{a: inst_sram_addr, rdy: cyc + 1});
                if (pend_q.size() > max_pend)
                    max_pend = pend_q.size();
            end
            @(posedge clk);
            #1;
            if (resp_en && pend_q.size() > 0 && pend_q[0].rdy <= cyc) begin
                inst_sram_data_ok = 1'b1;
                inst_sram_rdata   = inst_of(pend_q[0].a);
            end else begin
                inst_sram_data_ok = 1'b0;
                inst_sram_rdata   = 32'h0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (inst_sram_req && inst_sram_addr_ok) begin
                    hs_cnt++;
                    if (exp_addr.size() > 0)
                        chk("fetch_addr", inst_sram_addr, exp_addr.pop_front());
                end
                if (inst_sram_data_ok && first_dok < 0)
                    first_dok = cyc;
                if (fs_to_ds_valid && first_valid < 0)
                    first_valid = cyc;
                if (fs_to_ds_valid && ds_allowin) begin
                    pop_cyc.push_back(cyc);
                    if (exp_id.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL id_unexpected: got %h, expected no transfer", fs_to_ds_bus);
                    end else begin
                        chk("id_bus", fs_to_ds_bus, exp_id.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset             = 1'b1;
        ds_allowin        = 1'b1;
        br_bus            = '0;
        wb_ex             = 1'b0;
        wb_ertn           = 1'b0;
        csr_eentry        = 32'h0;
        csr_era           = 32'h0;
        inst_sram_addr_ok = 1'b1;
        step(1);

        // Streaming with one-cycle memory latency
        do_reset();
        chk("const_wr", inst_sram_wr, 0);
        chk("const_wstrb", inst_sram_wstrb, 0);
        chk("const_size", inst_sram_size, 2'b10);
        chk("const_wdata", inst_sram_wdata, 0);
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'h1C000000 + 32'(4 * i));
        for (int i = 0; i < 12; i++) exp_id.push_back(id_of(32'h1C000000 + 32'(4 * i)));
        drain("t1");
        chk("t1_latency", 65'(first_valid - first_dok), 65'(LAT));
        chk("t1_rate", 65'(pop_cyc[11] - pop_cyc[0]), 65'd11);
        chk("t1_addr_left", 65'(exp_addr.size()), 0);

        // ID stalled: request count bounded by queue depth
        ds_allowin = 1'b0;
        do_reset();
        h0 = hs_cnt;
        step(20);
        chk("t2_hs_count", 65'(hs_cnt - h0), 65'd4);
        chk("t2_req_idle", inst_sram_req, 0);
        for (int i = 0; i < 4; i++) exp_id.push_back(id_of(32'h1C000000 + 32'(4 * i)));
        drain("t2");

        // Branch with two requests outstanding
        resp_en = 1'b0;
        do_reset();
        h0 = hs_cnt;
        step(6);
        chk("t3_outst", 65'(hs_cnt - h0), 65'd2);
        chk("t3_req_blocked", inst_sram_req, 0);
        exp_addr.push_back(32'h1C000100);
        br_bus = {1'b0, 1'b1, 32'h1C000100};
        step(1);
        br_bus  = '0;
        resp_en = 1'b1;
        exp_id.push_back(id_of(32'h1C000100));
        drain("t3");
        chk("t3_addr_left", 65'(exp_addr.size()), 0);

        // Exception while a request waits for addr_ok
        inst_sram_addr_ok = 1'b0;
        do_reset();
        step(3);
        chk("t4_req_up", inst_sram_req, 1);
        chk("t4_addr", inst_sram_addr, 32'h1C000000);
        csr_eentry = 32'h1C008000;
        wb_ex      = 1'b1;
        step(1);
        wb_ex = 1'b0;
        step(2);
        chk("t4_req_held", inst_sram_req, 1);
        chk("t4_addr_held", inst_sram_addr, 32'h1C000000);
        exp_addr.push_back(32'h1C000000);
        exp_addr.push_back(32'h1C008000);
        inst_sram_addr_ok = 1'b1;
        exp_id.push_back(id_of(32'h1C008000));
        drain("t4");
        chk("t4_addr_left", 65'(exp_addr.size()), 0);

        // Misaligned branch target raises ADEF and halts fetch
        step(10);
        br_bus = {1'b0, 1'b1, 32'h1C000102};
        step(1);
        br_bus = '0;
        h0 = hs_cnt;
        step(10);
        chk("t5_no_fetch", 65'(hs_cnt - h0), 0);
        chk("t5_req_low", inst_sram_req, 0);
        exp_id.push_back({1'b1, 32'h0, 32'h1C000102});
        drain("t5");
        ds_allowin = 1'b1;
        step(5);
        chk("t5_halted", fs_to_ds_valid, 0);
        ds_allowin = 1'b0;
        csr_era = 32'h1C006000;
        wb_ertn = 1'b1;
        br_bus  = {1'b0, 1'b1, 32'h1C000300};
        step(1);
        wb_ertn = 1'b0;
        br_bus  = '0;
        exp_id.push_back(id_of(32'h1C006000));
        drain("t5_ertn");

        // Exception beats ertn
        step(10);
        wb_ex   = 1'b1;
        wb_ertn = 1'b1;
        step(1);
        wb_ex   = 1'b0;
        wb_ertn = 1'b0;
        exp_id.push_back(id_of(32'h1C008000));
        drain("t7");

        chk("max_outstanding_ok", 65'(max_pend <= MAXO), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
